// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: command, response and RAM-side signals of the RAM controller
interface ram_ctrl_if #(
  parameter int MEM_WIDTH = 16,
  parameter int ADDR_SIZE = 10,
  parameter int LEN_SIZE  = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_wr;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [LEN_SIZE-1:0]  cmd_len;
  logic [MEM_WIDTH-1:0] cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [MEM_WIDTH-1:0] rsp_data;
  logic                 rsp_last;
  logic [MEM_WIDTH-1:0] ram_din;
  logic [ADDR_SIZE-1:0] ram_addr_wr;
  logic [ADDR_SIZE-1:0] ram_addr_rd;
  logic                 ram_wr_en;
  logic                 ram_rd_en;
  logic                 ram_blk_select;
  logic [MEM_WIDTH-1:0] ram_dout;
  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_data, rsp_ready, ram_dout,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last, ram_din, ram_addr_wr, ram_addr_rd,
           ram_wr_en, ram_rd_en, ram_blk_select
  );
  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_data, rsp_ready, ram_dout,
    output cmd_ready, rsp_valid, rsp_data, rsp_last, ram_din, ram_addr_wr, ram_addr_rd,
           ram_wr_en, ram_rd_en, ram_blk_select
  );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-word writes and read bursts against a one-cycle-latency synchronous RAM
module ram_ctrl #(
  parameter int MEM_WIDTH = 16,
  parameter int ADDR_SIZE = 10,
  parameter int LEN_SIZE  = 4
) (
  input logic     clk,
  input logic     rst,
  ram_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_CAPT, RSP} state_t;
  state_t               state_q;
  logic                 cmd_ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_last_q;
  logic                 wr_en_q;
  logic                 rd_en_q;
  logic                 blk_q;
  logic [MEM_WIDTH-1:0] rsp_data_q;
  logic [MEM_WIDTH-1:0] din_q;
  logic [ADDR_SIZE-1:0] addr_wr_q;
  logic [ADDR_SIZE-1:0] addr_rd_q;
  logic [ADDR_SIZE-1:0] addr_rd_d;
  logic [ADDR_SIZE-1:0] base_q;
  logic [LEN_SIZE-1:0]  len_q;
  logic [LEN_SIZE-1:0]  beat_q;
  logic [LEN_SIZE-1:0]  beat_d;
  logic                 last_d;
  always_comb begin
    beat_d    = beat_q + LEN_SIZE'(1);
    addr_rd_d = base_q + ADDR_SIZE'(beat_d);
    last_d    = beat_q == len_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      blk_q       <= 1'b0;
      din_q       <= '0;
      addr_wr_q   <= '0;
      addr_rd_q   <= '0;
      base_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          cmd_ready_q <= 1'b0;
          blk_q       <= 1'b1;
          if (bus.cmd_wr) begin
            state_q   <= WRITE;
            wr_en_q   <= 1'b1;
            addr_wr_q <= bus.cmd_addr;
            din_q     <= bus.cmd_data;
          end else begin
            state_q   <= RD_ISSUE;
            rd_en_q   <= 1'b1;
            base_q    <= bus.cmd_addr;
            len_q     <= bus.cmd_len;
            beat_q    <= '0;
            addr_rd_q <= bus.cmd_addr;
          end
        end
        WRITE: begin
          state_q     <= IDLE;
          wr_en_q     <= 1'b0;
          blk_q       <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        RD_ISSUE: begin
          state_q <= RD_WAIT;
          rd_en_q <= 1'b0;
          blk_q   <= 1'b0;
        end
        RD_WAIT: state_q <= RD_CAPT;
        RD_CAPT: begin
          state_q     <= RSP;
          rsp_data_q  <= bus.ram_dout;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= last_d;
        end
        // beat is held here until the consumer takes it
        RSP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_last_q  <= 1'b0;
          if (last_d) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
          end else begin
            state_q   <= RD_ISSUE;
            beat_q    <= beat_d;
            addr_rd_q <= addr_rd_d;
            rd_en_q   <= 1'b1;
            blk_q     <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_last_q  <= 1'b0;
          wr_en_q     <= 1'b0;
          rd_en_q     <= 1'b0;
          blk_q       <= 1'b0;
        end
      endcase
    end
  end
  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_last       = rsp_last_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.ram_din        = din_q;
  assign bus.ram_addr_wr    = addr_wr_q;
  assign bus.ram_addr_rd    = addr_rd_q;
  assign bus.ram_wr_en      = wr_en_q;
  assign bus.ram_rd_en      = rd_en_q;
  assign bus.ram_blk_select = blk_q;
endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameters SHALL be: MEM_WIDTH, default 16, data width; ADDR_SIZE, default 10, address width; LEN_SIZE, default 4, burst-length field width.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  command accepted at edge where cmd_valid and cmd_ready are both 1.
REQ-006 cmd_wr  in  1  1 = single-word write, 0 = read burst.
REQ-007 cmd_addr  in  ADDR_SIZE  start address.
REQ-008 cmd_len  in  LEN_SIZE  read beats minus 1; ignored for writes.
REQ-009 cmd_data  in  MEM_WIDTH  write data.
REQ-010 rsp_valid  out  1  read beat present on rsp_data.
REQ-011 rsp_ready  in  1  consumer accepts beat when rsp_valid and rsp_ready are both 1.
REQ-012 rsp_data  out  MEM_WIDTH  read data.
REQ-013 rsp_last  out  1  marks final beat of a burst; qualified by rsp_valid.
REQ-014 ram_din  out  MEM_WIDTH  to RAM din.
REQ-015 ram_addr_wr, ram_addr_rd  out  ADDR_SIZE each  to RAM write and read address inputs.
REQ-016 ram_wr_en, ram_rd_en, ram_blk_select  out  1 each  to RAM enables.
REQ-017 ram_dout  in  MEM_WIDTH  from RAM; valid one clock after ram_rd_en is sampled.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_CAPT, RSP.
REQ-019 cmd_ready SHALL be 1 only in IDLE, decoded from state.
REQ-020 IDLE: on accept with cmd_wr=1 -> WRITE; with cmd_wr=0 -> RD_ISSUE, latching addr, len, and a beat counter cleared to 0.
REQ-021 WRITE, one cycle: ram_wr_en=1, ram_blk_select=1, ram_addr_wr and ram_din hold accepted values; next state IDLE.
REQ-022 RD_ISSUE, one cycle: ram_rd_en=1, ram_blk_select=1, ram_addr_rd=base+beat modulo 2^ADDR_SIZE; next state RD_WAIT.
REQ-023 RD_WAIT, one cycle, enables 0; RD_CAPT, one cycle, registers ram_dout into rsp_data; next state RSP.
REQ-024 RSP: rsp_valid=1; rsp_last=1 iff beat==len; rsp_data stable until accepted.
REQ-025 On accept in RSP: if beat==len -> IDLE, else beat+1 -> RD_ISSUE.
REQ-026 All outputs SHALL be registered; RAM enables and ram_blk_select SHALL be 0 in every state not named above.
REQ-027 Latency: write accepted at edge E0 drives RAM during E0..E1, so the RAM writes at E1. Read beat issued at edge E0 -> rsp_valid high after edge E3.
REQ-028 Write throughput SHALL be 1 per 2 clocks. Read throughput with rsp_ready held 1 SHALL be 1 beat per 4 clocks.
REQ-029 Address wrap: burst crossing 2^ADDR_SIZE-1 SHALL continue at 0.
REQ-030 Read accepted after a write SHALL return the new data (no hazard; the write completes before the read issues).
REQ-031 Back-pressure: rsp_ready=0 SHALL hold RSP indefinitely with no RAM activity.

Reset
REQ-032 rst=0 at an edge -> state IDLE, beat=0, rsp_valid=0, rsp_last=0, rsp_data=0, all ram_* outputs 0; cmd_ready=1 from the first cycle after rst=1.
REQ-033 Reset mid-burst SHALL abandon the burst; no further beats are presented. RAM contents are not affected by this block's reset.

Verification
REQ-034 After reset, write addr 0x005 data 0xA5A5, then read addr 0x005 len 0 -> one beat 0xA5A5, rsp_last=1, rsp_valid 3 edges after issue.
REQ-035 Write 0x3FE=0x1111 and 0x3FF=0x2222 and 0x000=0x3333; read addr 0x3FE len 2 -> 0x1111, 0x2222, 0x3333; rsp_last only on beat 3; ram_addr_rd sequence 0x3FE, 0x3FF, 0x000.
REQ-036 Read len 3 with rsp_ready=0 for 10 cycles on beat 1 -> rsp_data stable, ram_rd_en=0 throughout, burst then completes with 4 beats.
REQ-037 cmd_valid held 1 with alternating writes -> accepts exactly every 2nd edge; ram_wr_en a one-cycle pulse each.
REQ-038 Assert rst=0 during RSP of beat 2 of a len-7 burst -> next cycle rsp_valid=0 and cmd_ready=1; no further beats appear.
